// File: rtl/garage_door_ctrl.sv
// Garage-door motor controller: Moore FSM with edge-detected push-button, stop-in-travel,
// obstruction reversal, optional auto-close and a per-segment motor travel timeout.
module garage_door_ctrl #(
    parameter int AUTO_CLOSE_CYCLES    = 1000,
    parameter int MOTOR_TIMEOUT_CYCLES = 5000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Activate,
    input  logic       UP_Max,
    input  logic       DN_Max,
    input  logic       Obstruct,
    output logic       UP_M,
    output logic       DN_M,
    output logic       Fault,
    output logic [2:0] State
);

    localparam int MW = $clog2(MOTOR_TIMEOUT_CYCLES);
    localparam int AW = (AUTO_CLOSE_CYCLES > 0) ? $clog2(AUTO_CLOSE_CYCLES + 1) : 1;
    localparam logic [MW-1:0] MOVE_LAST = MW'(MOTOR_TIMEOUT_CYCLES - 1);
    localparam logic [AW-1:0] AUTO_LAST = AW'((AUTO_CLOSE_CYCLES > 0) ? AUTO_CLOSE_CYCLES - 1 : 0);
    localparam bit AUTO_EN = (AUTO_CLOSE_CYCLES != 0);

    typedef enum logic [2:0] {
        S_CLOSED  = 3'd0,
        S_OPENING = 3'd1,
        S_OPEN    = 3'd2,
        S_CLOSING = 3'd3,
        S_STOPPED = 3'd4,
        S_FAULT   = 3'd5
    } state_e;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_e;

    state_e          state_q, state_d;
    dir_e            last_dir_q, last_dir_d;
    logic            act_q;
    logic            act;
    logic [MW-1:0]   move_cnt_q, move_cnt_d;
    logic [AW-1:0]   auto_cnt_q, auto_cnt_d;
    logic            moving_d;

    // act_q resets high so a button already held through reset is not a command
    assign act = Activate & ~act_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_STOPPED;
            last_dir_q <= DIR_UP;
            act_q      <= 1'b1;
            move_cnt_q <= '0;
            auto_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            last_dir_q <= last_dir_d;
            act_q      <= Activate;
            move_cnt_q <= move_cnt_d;
            auto_cnt_q <= auto_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_dir_d = last_dir_q;
        if (state_q != S_FAULT && UP_Max && DN_Max) begin
            state_d = S_FAULT;
        end else begin
            case (state_q)
                S_OPENING: begin
                    if (UP_Max) begin
                        state_d = S_OPEN;
                    end else if (move_cnt_q == MOVE_LAST) begin
                        state_d = S_FAULT;
                    end else if (act) begin
                        state_d    = S_STOPPED;
                        last_dir_d = DIR_UP;
                    end
                end
                S_CLOSING: begin
                    if (DN_Max) begin
                        state_d = S_CLOSED;
                    end else if (move_cnt_q == MOVE_LAST) begin
                        state_d = S_FAULT;
                    end else if (Obstruct) begin
                        state_d = S_OPENING;
                    end else if (act) begin
                        state_d    = S_STOPPED;
                        last_dir_d = DIR_DN;
                    end
                end
                S_CLOSED: begin
                    if (act) begin
                        state_d = S_OPENING;
                    end
                end
                S_OPEN: begin
                    // an obstructed auto-close expiry restarts the timer via the counter logic
                    if (act && !Obstruct) begin
                        state_d = S_CLOSING;
                    end else if (AUTO_EN && auto_cnt_q == AUTO_LAST && !Obstruct) begin
                        state_d = S_CLOSING;
                    end
                end
                S_STOPPED: begin
                    if (act) begin
                        if (DN_Max) begin
                            state_d = S_OPENING;
                        end else if (UP_Max || last_dir_q == DIR_UP) begin
                            if (!Obstruct) begin
                                state_d = S_CLOSING;
                            end
                        end else begin
                            state_d = S_OPENING;
                        end
                    end
                end
                S_FAULT: begin
                    state_d = S_FAULT;
                end
                default: begin
                    state_d = S_FAULT;
                end
            endcase
        end
    end

    // counters clear whenever the state changes, which covers every travel-segment entry
    assign moving_d = (state_d == S_OPENING) || (state_d == S_CLOSING);

    always_comb begin
        move_cnt_d = '0;
        if (moving_d && state_d == state_q) begin
            if (move_cnt_q == MOVE_LAST) begin
                move_cnt_d = move_cnt_q;
            end else begin
                move_cnt_d = move_cnt_q + MW'(1);
            end
        end
    end

    always_comb begin
        auto_cnt_d = '0;
        if (AUTO_EN && state_q == S_OPEN && state_d == S_OPEN) begin
            if (auto_cnt_q == AUTO_LAST) begin
                auto_cnt_d = '0;
            end else begin
                auto_cnt_d = auto_cnt_q + AW'(1);
            end
        end
    end

    assign UP_M  = (state_q == S_OPENING);
    assign DN_M  = (state_q == S_CLOSING);
    assign Fault = (state_q == S_FAULT);
    assign State = state_q;

    motor_exclusive: assert property (@(posedge CLK) !(UP_M && DN_M));

endmodule
